// File: rtl/pos_check_arbiter.sv
// Two-player sprite position checker sharing one map lookup port.
// Define FIXED_PRIORITY_EN to always favour player 0 on ties.
module pos_check_arbiter #(
  parameter int OBJ_W      = 32,
  parameter int OBJ_H      = 32,
  parameter int LOOKUP_LAT = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [1:0]         req,
  input  logic signed [10:0] req_x0,
  input  logic signed [10:0] req_y0,
  input  logic signed [10:0] req_x1,
  input  logic signed [10:0] req_y1,
  output logic [1:0]         done,
  output logic [1:0]         valid_pos,
  output logic               busy,
  output logic               map_rd,
  output logic signed [10:0] map_x,
  output logic signed [10:0] map_y,
  input  logic               map_free
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    DONE
  } state_t;

  localparam logic signed [10:0] DX = 11'(OBJ_W - 1);
  localparam logic signed [10:0] DY = 11'(OBJ_H - 1);
  localparam logic [3:0]         LAT = 4'(LOOKUP_LAT);

  state_t             state_q, state_d;
  logic [1:0]         pend_q, pend_d;
  logic signed [10:0] px0_q, py0_q, px1_q, py1_q;
  logic signed [10:0] wx_q, wx_d, wy_q, wy_d;
  logic               gnt_q, gnt_d;
  logic               last_q, last_d;
  logic [1:0]         corner_q, corner_d;
  logic [3:0]         cnt_q, cnt_d;
  logic [1:0]         vpos_q, vpos_d;

  logic               grant;
  logic               pick;
  logic               last_eff;
  logic [1:0]         clr;

  // DONE already counts as the new last grant when it arbitrates
  assign last_eff = (state_q == DONE) ? gnt_q : last_q;

  always_comb begin
    pick = 1'b0;
    if (pend_q == 2'b11) begin
`ifdef FIXED_PRIORITY_EN
      pick = 1'b0;
`else
      pick = ~last_eff;
`endif
    end else begin
      pick = pend_q[1];
    end
  end

  always_comb begin
    state_d  = state_q;
    wx_d     = wx_q;
    wy_d     = wy_q;
    gnt_d    = gnt_q;
    last_d   = last_q;
    corner_d = corner_q;
    cnt_d    = cnt_q;
    vpos_d   = vpos_q;
    grant    = 1'b0;
    unique case (state_q)
      IDLE: begin
        grant = |pend_q;
      end
      ISSUE: begin
        cnt_d   = LAT;
        state_d = WAIT;
      end
      WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          if (!map_free || corner_q == 2'd3) begin
            vpos_d[gnt_q] = map_free;
            state_d       = DONE;
          end else begin
            corner_d = corner_q + 2'd1;
            state_d  = ISSUE;
          end
        end
      end
      DONE: begin
        last_d  = gnt_q;
        state_d = IDLE;
        // back-to-back service skips the idle cycle
        grant   = |pend_q;
      end
      default: state_d = IDLE;
    endcase
    if (grant) begin
      gnt_d    = pick;
      wx_d     = pick ? px1_q : px0_q;
      wy_d     = pick ? py1_q : py0_q;
      corner_d = 2'd0;
      state_d  = ISSUE;
    end
  end

  assign clr    = grant ? (pick ? 2'b10 : 2'b01) : 2'b00;
  assign pend_d = (pend_q & ~clr) | req;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      pend_q   <= 2'b00;
      px0_q    <= '0;
      py0_q    <= '0;
      px1_q    <= '0;
      py1_q    <= '0;
      wx_q     <= '0;
      wy_q     <= '0;
      gnt_q    <= 1'b0;
      last_q   <= 1'b1;
      corner_q <= 2'd0;
      cnt_q    <= 4'd0;
      vpos_q   <= 2'b00;
    end else begin
      state_q  <= state_d;
      pend_q   <= pend_d;
      wx_q     <= wx_d;
      wy_q     <= wy_d;
      gnt_q    <= gnt_d;
      last_q   <= last_d;
      corner_q <= corner_d;
      cnt_q    <= cnt_d;
      vpos_q   <= vpos_d;
      if (req[0]) begin
        px0_q <= req_x0;
        py0_q <= req_y0;
      end
      if (req[1]) begin
        px1_q <= req_x1;
        py1_q <= req_y1;
      end
    end
  end

  assign map_x     = corner_q[0] ? wx_q + DX : wx_q;
  assign map_y     = corner_q[1] ? wy_q + DY : wy_q;
  assign map_rd    = (state_q == ISSUE);
  assign busy      = (state_q != IDLE);
  assign valid_pos = vpos_q;
  assign done      = (state_q == DONE) ? (gnt_q ? 2'b10 : 2'b01) : 2'b00;

endmodule
